// File: rtl/ascon_perm_engine_pkg.sv
// Shared types, constants and helper functions for the Ascon permutation engine.
package ascon_perm_engine_pkg;

  typedef logic [63:0]      word_t;
  typedef logic [4:0][63:0] state_t;  // x0 = [4] ... x4 = [0]

  localparam int MAX_ROUNDS = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Round constant for schedule index i: high nibble counts down, low nibble counts up.
  function automatic logic [7:0] rc(input logic [3:0] i);
    return {4'd15 - i, i};
  endfunction

  // Requests above the schedule length run the full permutation.
  function automatic logic [3:0] sat12(input logic [3:0] r);
    return (r > 4'd12) ? 4'd12 : r;
  endfunction

  function automatic word_t ror64(input word_t x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Ascon 5-bit S-box, column bit 4 is x0 and bit 0 is x4.
  function automatic logic [4:0] sbox5(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0b;  5'h02: y = 5'h1f;  5'h03: y = 5'h14;
      5'h04: y = 5'h1a;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1b;  5'h09: y = 5'h05;  5'h0a: y = 5'h08;  5'h0b: y = 5'h12;
      5'h0c: y = 5'h1d;  5'h0d: y = 5'h03;  5'h0e: y = 5'h06;  5'h0f: y = 5'h1c;
      5'h10: y = 5'h1e;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0e;
      5'h14: y = 5'h00;  5'h15: y = 5'h0d;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0c;  5'h1a: y = 5'h01;  5'h1b: y = 5'h19;
      5'h1c: y = 5'h16;  5'h1d: y = 5'h0a;  5'h1e: y = 5'h0f;  5'h1f: y = 5'h17;
      default: y = 5'h00;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/ascon_perm_engine_if.sv
// Request/response bundle between the mode controller and the permutation engine.
interface ascon_perm_engine_if;
  import ascon_perm_engine_pkg::*;

  logic       in_valid_i;
  logic       in_ready_o;
  state_t     state_i;
  logic [3:0] rounds_i;
  logic       abort_i;
  logic       out_valid_o;
  logic       out_ready_i;
  state_t     state_o;
  logic       busy_o;

  modport master (
    output in_valid_i, state_i, rounds_i, abort_i, out_ready_i,
    input  in_ready_o, out_valid_o, state_o, busy_o
  );

  modport slave (
    input  in_valid_i, state_i, rounds_i, abort_i, out_ready_i,
    output in_ready_o, out_valid_o, state_o, busy_o
  );
endinterface

// File: rtl/ascon_perm_engine_chk.sv
// Invariant monitor for the permutation engine's control state.
module ascon_perm_engine_chk
  import ascon_perm_engine_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic [3:0] rc_idx,
  input logic       out_valid,
  input fsm_e       fsm
);

  a_rc_idx_range: assert property (@(posedge clk) disable iff (rst) rc_idx <= 4'd12);

  a_valid_only_in_done: assert property (@(posedge clk) disable iff (rst) out_valid |-> (fsm == DONE));

endmodule

// File: rtl/ascon_perm_engine_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear diffusion.
// With en_i low the state passes through untouched.
module ascon_round
  import ascon_perm_engine_pkg::*;
(
  input  state_t     state_i,
  input  logic [7:0] rc_i,
  input  logic       en_i,
  output state_t     state_o
);

  state_t add_s;
  state_t sub_s;
  state_t lin_s;

  // Constant addition into the low byte of x2
  always_comb begin
    add_s = state_i;
    add_s[2][7:0] = state_i[2][7:0] ^ rc_i;
  end

  // Column-wise substitution, one S-box per bit position
  always_comb begin
    logic [4:0] col_v;
    logic [4:0] sbx_v;
    sub_s = '0;
    col_v = 5'd0;
    sbx_v = 5'd0;
    for (int j = 0; j < 64; j++) begin
      col_v = {add_s[4][j], add_s[3][j], add_s[2][j], add_s[1][j], add_s[0][j]};
      sbx_v = sbox5(col_v);
      sub_s[4][j] = sbx_v[4];
      sub_s[3][j] = sbx_v[3];
      sub_s[2][j] = sbx_v[2];
      sub_s[1][j] = sbx_v[1];
      sub_s[0][j] = sbx_v[0];
    end
  end

  // Per-lane linear diffusion with the fixed Ascon rotation pairs
  always_comb begin
    lin_s[4] = sub_s[4] ^ ror64(sub_s[4], 19) ^ ror64(sub_s[4], 28);
    lin_s[3] = sub_s[3] ^ ror64(sub_s[3], 61) ^ ror64(sub_s[3], 39);
    lin_s[2] = sub_s[2] ^ ror64(sub_s[2], 1)  ^ ror64(sub_s[2], 6);
    lin_s[1] = sub_s[1] ^ ror64(sub_s[1], 10) ^ ror64(sub_s[1], 17);
    lin_s[0] = sub_s[0] ^ ror64(sub_s[0], 7)  ^ ror64(sub_s[0], 41);
  end

  // Bypass for stages beyond the rounds still to run this cycle
  always_comb begin
    if (en_i) begin
      state_o = lin_s;
    end else begin
      state_o = state_i;
    end
  end

endmodule

// File: rtl/ascon_perm_engine.sv
// Ascon permutation engine: runs the last r rounds of the 12-round constant
// schedule on a 320-bit state, UNROLL rounds per clock, valid/ready on both sides.
module ascon_perm_engine
  import ascon_perm_engine_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input logic                clk,
  input logic                rst,
  ascon_perm_engine_if.slave bus
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 3 || UNROLL == 4 ||
        UNROLL == 6 || UNROLL == 12)) begin : g_bad_unroll
    $error("ascon_perm_engine: UNROLL must be one of 1,2,3,4,6,12");
  end

  localparam logic [3:0] UNROLL_W = 4'(UNROLL);

  fsm_e       fsm_r;
  fsm_e       fsm_nxt_s;
  state_t     state_r;
  state_t     state_nxt_s;
  logic [3:0] rc_idx_r;
  logic [3:0] rc_idx_nxt_s;
  logic       out_valid_r;
  logic       busy_r;
  logic [3:0] rem_s;
  logic [3:0] n_s;
  logic [3:0] req_rounds_s;
  state_t     chain_s [0:UNROLL];

  assign req_rounds_s = sat12(bus.rounds_i);

  // Rounds applied this cycle: a full unroll, or whatever is left of the schedule
  always_comb begin
    rem_s = 4'd12 - rc_idx_r;
    if (rem_s < UNROLL_W) begin
      n_s = rem_s;
    end else begin
      n_s = UNROLL_W;
    end
  end

  assign chain_s[0] = state_r;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    logic [3:0] idx_s;
    logic       en_s;
    assign idx_s = rc_idx_r + 4'(k);
    assign en_s  = (4'(k) < n_s);
    ascon_round u_round (
      .state_i (chain_s[k]),
      .rc_i    (rc(idx_s)),
      .en_i    (en_s),
      .state_o (chain_s[k+1])
    );
  end

  // Next-state and datapath selection; abort overrides every state
  always_comb begin
    fsm_nxt_s    = fsm_r;
    state_nxt_s  = state_r;
    rc_idx_nxt_s = rc_idx_r;
    if (bus.abort_i) begin
      fsm_nxt_s    = IDLE;
      rc_idx_nxt_s = 4'd0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (bus.in_valid_i) begin
            state_nxt_s  = bus.state_i;
            rc_idx_nxt_s = 4'd12 - req_rounds_s;
            if (req_rounds_s == 4'd0) begin
              fsm_nxt_s = DONE;
            end else begin
              fsm_nxt_s = RUN;
            end
          end else begin
            fsm_nxt_s = IDLE;
          end
        end
        RUN: begin
          state_nxt_s  = chain_s[UNROLL];
          rc_idx_nxt_s = rc_idx_r + n_s;
          if ((rc_idx_r + n_s) == 4'd12) begin
            fsm_nxt_s = DONE;
          end else begin
            fsm_nxt_s = RUN;
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            fsm_nxt_s = IDLE;
          end else begin
            fsm_nxt_s = DONE;
          end
        end
        default: begin
          fsm_nxt_s    = IDLE;
          rc_idx_nxt_s = 4'd0;
        end
      endcase
    end
  end

  // State register with synchronous reset; status outputs registered from next state
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r       <= IDLE;
      state_r     <= '0;
      rc_idx_r    <= 4'd0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      fsm_r       <= fsm_nxt_s;
      state_r     <= state_nxt_s;
      rc_idx_r    <= rc_idx_nxt_s;
      out_valid_r <= (fsm_nxt_s == DONE);
      busy_r      <= (fsm_nxt_s == RUN) || (fsm_nxt_s == DONE);
    end
  end

  assign bus.in_ready_o  = (fsm_r == IDLE) && !rst;
  assign bus.out_valid_o = out_valid_r;
  assign bus.busy_o      = busy_r;
  assign bus.state_o     = state_r;

  ascon_perm_engine_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .rc_idx    (rc_idx_r),
    .out_valid (out_valid_r),
    .fsm       (fsm_r)
  );

endmodule
